// File: rtl/matvec_engine.sv
// rtl/matvec_engine.sv - self-sequenced signed matrix-vector multiplier, y = W*x
// Loads x then row-major W over a valid/ready stream, one saturating MAC, streams M row results.
module matvec_engine #(
    parameter int DATA_W = 14,
    parameter int N      = 8,
    parameter int M      = 8,
    parameter int ACC_W  = 2 * DATA_W,
    localparam int ROW_W = (M > 1) ? $clog2(M) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     keep_x,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic [ROW_W-1:0]         out_row,
    output logic                     out_sat,
    output logic                     busy,
    output logic                     done
);
    localparam int XA_W   = $clog2(N);
    localparam int WA_W   = $clog2(M * N);
    localparam int CNT_W  = $clog2(N + 1);
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_X, S_LOAD_W, S_MAC, S_OUT} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      sat_q, sat_d;
    logic                      done_q, done_d;
    logic                      x_loaded_q, x_loaded_d;

    logic signed [DATA_W-1:0]  x_mem_q [N];
    logic signed [DATA_W-1:0]  w_mem_q [M*N];
    logic signed [DATA_W-1:0]  x_rd_q, w_rd_q;

    logic                      x_we, w_we;
    logic [XA_W-1:0]           x_addr;
    logic [WA_W-1:0]           w_addr;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W:0]     sum;
    logic                      ovf;
    logic signed [ACC_W-1:0]   acc_next;
    logic                      col_last, row_last;

    // The same counter walks columns during loads and MAC steps, so addressing is shared.
    assign x_addr   = XA_W'(cnt_q);
    assign w_addr   = WA_W'(int'(row_q) * N + int'(cnt_q));
    assign col_last = (cnt_q == CNT_W'(N - 1));
    assign row_last = (row_q == ROW_W'(M - 1));

    assign prod = x_rd_q * w_rd_q;
    assign sum  = {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod} + {acc_q[ACC_W-1], acc_q};
    assign ovf  = (sum[ACC_W] != sum[ACC_W-1]);

    always_comb begin
        acc_next = sum[ACC_W-1:0];
        if (ovf) begin
            acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        acc_d      = acc_q;
        sat_d      = sat_q;
        done_d     = 1'b0;
        x_loaded_d = x_loaded_q;
        x_we       = 1'b0;
        w_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    row_d   = '0;
                    state_d = (keep_x && x_loaded_q) ? S_LOAD_W : S_LOAD_X;
                end
            end
            S_LOAD_X: begin
                if (in_valid) begin
                    x_we = 1'b1;
                    if (col_last) begin
                        cnt_d      = '0;
                        x_loaded_d = 1'b1;
                        state_d    = S_LOAD_W;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_LOAD_W: begin
                if (in_valid) begin
                    w_we = 1'b1;
                    if (col_last) begin
                        cnt_d = '0;
                        if (row_last) begin
                            row_d   = '0;
                            acc_d   = '0;
                            sat_d   = 1'b0;
                            state_d = S_MAC;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_MAC: begin
                // Step 0 only primes the registered reads; steps 1..N accumulate.
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q != '0) begin
                    acc_d = acc_next;
                    sat_d = sat_q | ovf;
                end
                if (cnt_q == CNT_W'(N)) begin
                    cnt_d   = '0;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (row_last) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        cnt_d   = '0;
                        acc_d   = '0;
                        sat_d   = 1'b0;
                        state_d = S_MAC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            row_q      <= '0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            done_q     <= 1'b0;
            x_loaded_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            done_q     <= done_d;
            x_loaded_q <= x_loaded_d;
        end
    end

    // Operand storage is deliberately unreset so x survives between jobs.
    always_ff @(posedge clk) begin
        if (x_we) x_mem_q[x_addr] <= in_data;
        if (w_we) w_mem_q[w_addr] <= in_data;
        x_rd_q <= x_mem_q[x_addr];
        w_rd_q <= w_mem_q[w_addr];
    end

    assign in_ready  = (state_q == S_LOAD_X) || (state_q == S_LOAD_W);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = acc_q;
    assign out_row   = row_q;
    assign out_sat   = sat_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_matvec_engine.sv
// tb/tb_matvec_engine.sv - directed scoreboard bench for matvec_engine
// Expected rows come from a saturating reference model of y = W*x pushed at load time.
module tb_matvec_engine;
    localparam int DATA_W = 14;
    localparam int N      = 8;
    localparam int M      = 8;
    localparam int ACC_W  = 28;
    localparam longint MAXV = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (ACC_W - 1));

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic                     keep_x = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [ACC_W-1:0]  out_data;
    logic [2:0]               out_row;
    logic                     out_sat;
    logic                     busy;
    logic                     done;

    typedef struct {
        longint data;
        longint row;
        longint sat;
    } exp_t;

    exp_t                     sb_q[$];
    logic signed [DATA_W-1:0] xv [N];
    logic signed [DATA_W-1:0] xs [N];
    logic signed [DATA_W-1:0] wv [M*N];
    int                       n_vec = 0;
    int                       n_fail = 0;

    matvec_engine #(.DATA_W(DATA_W), .N(N), .M(M), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .keep_x(keep_x),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_sat(out_sat), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input longint obs, input longint expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push_model();
        for (int r = 0; r < M; r++) begin
            exp_t   e;
            longint acc;
            acc   = 0;
            e.sat = 0;
            for (int k = 0; k < N; k++) begin
                acc = acc + longint'(xs[k]) * longint'(wv[r*N+k]);
                if (acc > MAXV) begin acc = MAXV; e.sat = 1; end
                if (acc < MINV) begin acc = MINV; e.sat = 1; end
            end
            e.data = acc;
            e.row  = r;
            sb_q.push_back(e);
        end
    endtask

    task automatic send(input logic signed [DATA_W-1:0] d);
        bit hs;
        bit ok;
        ok       = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 50 && !ok; t++) begin
            hs = in_ready;
            @(negedge clk);
            if (hs) ok = 1;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic recv(input int nrows, input int stall_row);
        for (int r = 0; r < nrows; r++) begin
            int     c;
            longint d0;
            longint r0;
            exp_t   e;
            c = 0;
            while (!out_valid && c < 100) begin
                @(negedge clk);
                c++;
            end
            check("mac_latency", c, N + 1);
            if (r == stall_row) begin
                d0 = out_data;
                r0 = out_row;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, d0);
                    check("stall_row", out_row, r0);
                end
            end
            e = sb_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_row", out_row, e.row);
            check("out_sat", out_sat, e.sat);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            if (r == M - 1) begin
                check("done_pulse", done, 1);
                check("busy_at_done", busy, 0);
                @(negedge clk);
                check("done_single", done, 0);
            end else begin
                check("no_early_done", done, 0);
            end
        end
    endtask

    task automatic run_job(input bit keep, input bit full, input bit gaps,
                           input int stall_row, input int nrows);
        start    = 1'b1;
        keep_x   = keep;
        in_valid = 1'b1;          // ignored while idle
        in_data  = 14'sh1555;
        @(negedge clk);
        start    = 1'b0;
        keep_x   = 1'b0;
        in_valid = 1'b0;
        check("busy_after_start", busy, 1);
        check("in_ready_after_start", in_ready, 1);
        if (full) begin
            for (int k = 0; k < N; k++) begin
                xs[k] = xv[k];
                send(xv[k]);
                if (gaps && k[0]) @(negedge clk);
            end
        end
        for (int i = 0; i < M * N; i++) begin
            send(wv[i]);
            if (gaps && i[0] && i < M * N - 1) @(negedge clk);
        end
        check("in_ready_after_load", in_ready, 0);
        push_model();
        recv(nrows, stall_row);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_row"}, out_row, 0);
        check({tag, "_out_sat"}, out_sat, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Basic: x=1, W[r][k]=r
        for (int k = 0; k < N; k++) xv[k] = 14'sd1;
        for (int i = 0; i < M * N; i++) wv[i] = DATA_W'(i / N);
        run_job(1'b0, 1'b1, 1'b0, -1, M);

        // Signed mix: x=k-4, W diagonal -3
        for (int k = 0; k < N; k++) xv[k] = DATA_W'(k - 4);
        for (int i = 0; i < M * N; i++) wv[i] = (i / N == i % N) ? -14'sd3 : 14'sd0;
        run_job(1'b0, 1'b1, 1'b0, -1, M);

        // Positive saturation
        for (int k = 0; k < N; k++) xv[k] = -14'sd8192;
        for (int i = 0; i < M * N; i++) wv[i] = -14'sd8192;
        run_job(1'b0, 1'b1, 1'b0, -1, M);

        // Negative saturation
        for (int i = 0; i < M * N; i++) wv[i] = 14'sd8191;
        run_job(1'b0, 1'b1, 1'b0, -1, M);

        // Backpressure and input gaps on the basic data
        for (int k = 0; k < N; k++) xv[k] = 14'sd1;
        for (int i = 0; i < M * N; i++) wv[i] = DATA_W'(i / N);
        run_job(1'b0, 1'b1, 1'b1, 3, M);

        // Reuse: job A loads x, job B keeps it with a fresh W only
        for (int k = 0; k < N; k++) xv[k] = DATA_W'(k - 4);
        for (int i = 0; i < M * N; i++) wv[i] = DATA_W'(int'($urandom_range(0, 400)) - 200);
        run_job(1'b0, 1'b1, 1'b0, -1, M);
        for (int k = 0; k < N; k++) xv[k] = 14'sd7;
        for (int i = 0; i < M * N; i++) wv[i] = DATA_W'(int'($urandom_range(0, 400)) - 200);
        run_job(1'b1, 1'b0, 1'b0, -1, M);

        // Reset during MAC of row 2
        run_job(1'b0, 1'b1, 1'b0, -1, 2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midjob_reset");
        sb_q.delete();
        repeat (N + 4) @(negedge clk);
        check("no_done_after_reset", done, 0);
        check("idle_after_reset", busy, 0);

        // After reset keep_x must still demand a full x load
        for (int k = 0; k < N; k++) xv[k] = DATA_W'(k + 1);
        for (int i = 0; i < M * N; i++) wv[i] = DATA_W'(int'($urandom_range(0, 2000)) - 1000);
        run_job(1'b1, 1'b1, 1'b0, -1, M);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/matvec_engine.md
# matvec_engine

Parametrised, self-sequenced signed matrix-vector multiplier: y = W·x. It loads a vector x (N elements) and a matrix W (M×N, row-major) over a valid/ready input stream. It then computes each row with a single saturating multiply-accumulate unit and emits M results over a valid/ready output stream. It is the generalised successor of the fixed 8×8, externally-addressed MAC datapath: width, depth and row count are parametric, the FSM and addressing are internal, and it adds backpressure, per-row saturation reporting and x-vector reuse.

## Interface
- DATA_W, 14, signed element width of x and W.
- N, 8, vector length / columns of W (≥2).
- M, 8, rows of W / number of results (≥1).
- ACC_W, 2*DATA_W, accumulator and result width (≥2*DATA_W).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- keep_x  in  1  sampled with start; 1 = reuse stored x, skip x load.
- in_valid  in  1  input word valid.
- in_ready  out  1  engine accepts input word.
- in_data  in  DATA_W  signed input word.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  ACC_W  signed row result.
- out_row  out  clog2(M) (min 1)  row index of out_data.
- out_sat  out  1  saturation occurred while accumulating this row.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse after last row is accepted.

## Operation
- States: IDLE, LOAD_X, LOAD_W, MAC, OUT.
- IDLE: in_ready=0, out_valid=0. On start=1, go to LOAD_W if keep_x=1 and x_loaded=1; otherwise go to LOAD_X. start outside IDLE is ignored.
- LOAD_X: in_ready=1. Each handshake (in_valid&in_ready) writes x[k] with k=0..N-1. After the N-th handshake, set x_loaded=1 and go to LOAD_W.
- LOAD_W: in_ready=1. Each handshake writes W[r][k], k fastest. After the M·N-th handshake, row:=0 and go to MAC. Gaps in in_valid stall the load without losing position.
- MAC per row: clear the accumulator and sat flag on entry. Storage reads are registered (1-cycle latency), so MAC lasts N+1 cycles: 1 fill cycle, then N accumulate cycles. Then go to OUT.
- Arithmetic: the 2·DATA_W product is sign-extended to ACC_W. acc := sat(acc + prod), clamped to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. Any clamp sets the row's sticky sat flag. Clamping is per step, and the accumulator continues from the clamped value.
- OUT: out_valid=1 and out_data/out_row/out_sat are held stable until out_ready=1. On handshake: if row==M−1, pulse done and go to IDLE; otherwise row+1 and go to MAC.
- x/W storage is not reset and is not cleared between jobs. x_loaded is cleared only by rst.
- keep_x=1 with x_loaded=0 (e.g. first job after reset) behaves as keep_x=0.

## Timing
- Reset (rst=1 at an edge): next cycle state=IDLE, in_ready=0, out_valid=0, out_data=0, out_row=0, out_sat=0, busy=0, done=0, x_loaded=0.
- rst dominates every other input in the same cycle, including mid-load, mid-MAC or in OUT with a pending handshake. Partial results are discarded.
- start accepted at edge t: busy=1 and in_ready=1 from cycle t+1.
- Last load handshake at edge t, or OUT handshake at edge t for a non-last row: MAC runs over cycles t+1..t+N+1, and out_valid=1 from cycle t+N+2.
- Best-case job with no stalls: 1 + (N if x loaded) + M·N + M·(N+2) cycles from start to done.
- done is high for exactly one cycle, the cycle after the final OUT handshake; busy=0 in that same cycle. A start in that cycle is accepted.
- out_valid never drops without a handshake except on rst.
- in_valid asserted while in_ready=0 has no effect.

## Test plan
- Basic (defaults): x[k]=1, W[r][k]=r. Expect rows 0..7 = 0,8,16,…,56; out_sat=0; done pulses once.
- Signed mix: x[k]=k−4, W[r][k]=(r==k)?−3:0. Expect out_data[r] = −3·(r−4), i.e. 12,9,6,3,0,−3,−6,−9.
- Positive saturation: x=W=−8192 everywhere. Expect out_data=134217727 and out_sat=1 on every row. Negative case: x=−8192, W=8191. Expect −134217728 and out_sat=1.
- Backpressure and stalls: in_valid toggled 1/0 during load, out_ready held 0 for 5 cycles on row 3. Expect out_data/out_row stable while stalled, no row skipped, results identical to the stall-free run.
- Reuse: run job A, then start with keep_x=1 and a new W (M·N words only). Expect results computed with A's x, and in_ready deasserting after exactly 64 words. After rst, keep_x=1 must request a full N+M·N load.
- Reset mid-job: rst during MAC of row 2. Expect all outputs at reset values next cycle, no done pulse, and a clean subsequent job.
